// File: rtl/ram32x4_arbiter.sv
// ram32x4_arbiter: shares one single-port 32x4 synchronous RAM between
// requesters A and B, and adds a sweep engine that writes CLEAR_VALUE to
// every address.
// Build option: define RAM_ARB_FIXED_PRIO_EN so that A always wins a tie.
// Without it, ties alternate round-robin.
module ram32x4_arbiter #(
  parameter int AW = 5,
  parameter int DW = 4,
  parameter logic [DW-1:0] CLEAR_VALUE = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_a,
  input  logic          req_b,
  input  logic          we_a,
  input  logic          we_b,
  input  logic [AW-1:0] addr_a,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_a,
  input  logic [DW-1:0] wdata_b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          rvalid_a,
  output logic          rvalid_b,
  output logic [DW-1:0] rdata,
  input  logic          clr_start,
  output logic          busy,
  output logic          clr_done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state, state_next;
  logic [AW-1:0] cnt;
  logic [AW-1:0] addr_hold;
  logic [DW-1:0] wdata_hold;
  logic          a_wins_tie;

`ifdef RAM_ARB_FIXED_PRIO_EN
  assign a_wins_tie = 1'b1;
`else
  // Set when B received the most recent grant; reset makes A win the first tie.
  logic last_b;

  // Track which requester was granted last, only on cycles that issue a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_b <= 1'b1;
    end else if (gnt_a) begin
      last_b <= 1'b0;
    end else if (gnt_b) begin
      last_b <= 1'b1;
    end
  end

  assign a_wins_tie = last_b;
`endif

  // Read data is simply passed through; rvalid_x says who owns it.
  assign rdata = mem_rdata;

  // Next state, grants and RAM drive; outputs are held quiet while in reset.
  always_comb begin
    state_next = state;
    gnt_a      = 1'b0;
    gnt_b      = 1'b0;
    busy       = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = addr_hold;
    mem_wdata  = wdata_hold;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (clr_start) begin
            state_next = CLEAR;
          end else if (req_a && (!req_b || a_wins_tie)) begin
            gnt_a     = 1'b1;
            mem_we    = we_a;
            mem_addr  = addr_a;
            mem_wdata = wdata_a;
          end else if (req_b) begin
            gnt_b     = 1'b1;
            mem_we    = we_b;
            mem_addr  = addr_b;
            mem_wdata = wdata_b;
          end
        end
        CLEAR: begin
          busy      = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = cnt;
          mem_wdata = CLEAR_VALUE;
          if (cnt == {AW{1'b1}}) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Sweep address counter: runs only while clearing, parked at zero otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == CLEAR) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  // One-cycle completion pulse after the edge that writes the last address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_done <= 1'b0;
    end else begin
      clr_done <= (state == CLEAR) && (cnt == {AW{1'b1}});
    end
  end

  // Read-valid pulses follow a granted read by one cycle, matching RAM latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
    end else begin
      rvalid_a <= gnt_a && !we_a;
      rvalid_b <= gnt_b && !we_b;
    end
  end

  // Remember the last RAM address/data so idle cycles keep the bus steady.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_hold  <= '0;
      wdata_hold <= '0;
    end else begin
      addr_hold  <= mem_addr;
      wdata_hold <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_ram32x4_arbiter.sv
// Self-checking bench for ram32x4_arbiter: directed scenarios followed by
// randomized traffic, all checked against a behavioural model of the
// arbitration and sweep rules plus a reference copy of the RAM contents.
module tb_ram32x4_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a, req_b, we_a, we_b;
  logic [4:0] addr_a, addr_b;
  logic [3:0] wdata_a, wdata_b;
  logic       gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [3:0] rdata;
  logic       clr_start, busy, clr_done;
  logic [4:0] mem_addr;
  logic       mem_we;
  logic [3:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  ram32x4_arbiter dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata(rdata), .clr_start(clr_start), .busy(busy), .clr_done(clr_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // RAM array attached to the arbiter: registered read, write at the edge.
  logic [3:0] ram [32];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [3:0] ref_mem [32];
  bit         m_clear, m_last_b, m_pa, m_pb, m_done;
  int         m_cnt;
  logic [3:0] m_da, m_db;
  logic [4:0] m_hold;
  bit         last_ga, last_gb, obs_busy, obs_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_clear = 0; m_cnt = 0; m_last_b = 1; m_pa = 0; m_pb = 0;
    m_done = 0; m_hold = '0;
  endtask

  // One clock cycle: drive inputs, check against the model mid-cycle, advance.
  task automatic tick(input bit ra, input bit wa, input logic [4:0] aa, input logic [3:0] da,
                      input bit rb, input bit wb, input logic [4:0] ab, input logic [3:0] db,
                      input bit cs);
    bit ea, eb;
    req_a = ra; we_a = wa; addr_a = aa; wdata_a = da;
    req_b = rb; we_b = wb; addr_b = ab; wdata_b = db;
    clr_start = cs;
    #4;
    chk("rvalid_a", rvalid_a, m_pa);
    chk("rvalid_b", rvalid_b, m_pb);
    if (m_pa) chk("rdata_a", rdata, m_da);
    if (m_pb) chk("rdata_b", rdata, m_db);
    chk("clr_done", clr_done, m_done);
    chk("busy", busy, m_clear);
    obs_busy = busy;
    obs_done = clr_done;
    ea = 0; eb = 0;
    if (!m_clear && !cs) begin
      if (ra && rb) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
        ea = 1;
`else
        ea = m_last_b;
        eb = !m_last_b;
`endif
      end else begin
        ea = ra;
        eb = rb;
      end
    end
    chk("gnt_a", gnt_a, ea);
    chk("gnt_b", gnt_b, eb);
    if (m_clear) begin
      chk("clr_we", mem_we, 1);
      chk("clr_addr", mem_addr, m_cnt);
      chk("clr_wdata", mem_wdata, 0);
    end else if (ea) begin
      chk("a_we", mem_we, wa);
      chk("a_addr", mem_addr, aa);
      if (wa) chk("a_wdata", mem_wdata, da);
    end else if (eb) begin
      chk("b_we", mem_we, wb);
      chk("b_addr", mem_addr, ab);
      if (wb) chk("b_wdata", mem_wdata, db);
    end else begin
      chk("idle_we", mem_we, 0);
      chk("idle_addr_hold", mem_addr, m_hold);
    end
    m_pa = ea && !wa; m_da = ref_mem[aa];
    m_pb = eb && !wb; m_db = ref_mem[ab];
    m_done = m_clear && (m_cnt == 31);
    if (m_clear) begin
      ref_mem[m_cnt] = 4'h0;
      m_hold = m_cnt[4:0];
      if (m_cnt == 31) begin
        m_clear = 0;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end else begin
      if (ea) begin
        if (wa) ref_mem[aa] = da;
        m_hold = aa;
        m_last_b = 0;
      end
      if (eb) begin
        if (wb) ref_mem[ab] = db;
        m_hold = ab;
        m_last_b = 1;
      end
      if (cs) begin
        m_clear = 1;
        m_cnt = 0;
      end
    end
    last_ga = ea; last_gb = eb;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_tick();
    tick(0, 0, 5'd0, 4'h0, 0, 0, 5'd0, 4'h0, 0);
  endtask

  // Assert reset asynchronously mid-cycle and check outputs drop at once.
  task automatic do_reset();
    req_a = 0; req_b = 0; we_a = 0; we_b = 0; clr_start = 0;
    rst = 1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_clr_done", clr_done, 0);
    chk("rst_gnt_a", gnt_a, 0);
    chk("rst_gnt_b", gnt_b, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rvalid_a", rvalid_a, 0);
    chk("rst_rvalid_b", rvalid_b, 0);
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask

  task automatic read_all_a();
    for (int i = 0; i < 32; i++) tick(1, 0, i[4:0], 4'h0, 0, 0, 5'd0, 4'h0, 0);
    idle_tick();
  endtask

  task automatic fill_a(input logic [3:0] v);
    for (int i = 0; i < 32; i++) tick(1, 1, i[4:0], v, 0, 0, 5'd0, 4'h0, 0);
  endtask

  initial begin
    logic [7:0] seq;
    logic [7:0] seq_exp;
    int  busy_cnt, done_cnt, gb_in_sweep;
    bit  ha, hwa, hb, hwb;
    logic [4:0] haa, hab;
    logic [3:0] hda, hdb;

    for (int i = 0; i < 32; i++) begin
      ram[i] = 4'h0;
      ref_mem[i] = 4'h0;
    end
    req_a = 0; req_b = 0; we_a = 0; we_b = 0; addr_a = 0; addr_b = 0;
    wdata_a = 0; wdata_b = 0; clr_start = 0;
    rst = 1;
    #7;
    do_reset();

    // A writes 5 = A, later reads it back.
    tick(1, 1, 5'd5, 4'hA, 0, 0, 5'd0, 4'h0, 0);
    idle_tick();
    tick(1, 0, 5'd5, 4'h0, 0, 0, 5'd0, 4'h0, 0);
    chk("a_read_gnt", last_ga, 1);
    idle_tick();
    chk("a_read_back", rdata, 4'hA);

    // Both requesting reads for four cycles from a fresh reset.
    do_reset();
    seq = '0;
    for (int i = 0; i < 4; i++) begin
      tick(1, 0, 5'd5, 4'h0, 1, 0, 5'd6, 4'h0, 0);
      seq = {seq[5:0], last_ga, last_gb};
    end
    idle_tick();
`ifdef RAM_ARB_FIXED_PRIO_EN
    seq_exp = 8'b10101010;
`else
    seq_exp = 8'b10011001;
`endif
    chk("tie_grant_sequence", seq, seq_exp);

    // Fill with F, read before clr_start, sweep with B held, restart ignored.
    fill_a(4'hF);
    tick(1, 0, 5'd2, 4'h0, 0, 0, 5'd0, 4'h0, 0);
    tick(1, 0, 5'd3, 4'h0, 1, 0, 5'd7, 4'h0, 1);
    chk("no_gnt_on_clr_start", {last_ga, last_gb}, 2'b00);
    busy_cnt = 0; done_cnt = 0; gb_in_sweep = 0;
    for (int i = 0; i < 33; i++) begin
      tick(0, 0, 5'd0, 4'h0, 1, 0, 5'd7, 4'h0, (i == 15));
      if (obs_busy) busy_cnt++;
      if (obs_done) done_cnt++;
      if (obs_busy && last_gb) gb_in_sweep++;
    end
    chk("sweep_busy_cycles", busy_cnt, 32);
    chk("sweep_done_pulses", done_cnt, 1);
    chk("sweep_no_gnt_b", gb_in_sweep, 0);
    chk("gnt_b_after_sweep", last_gb, 1);
    idle_tick();
    read_all_a();

    // Reset during sweep cycle 10: partial clear is left in place.
    fill_a(4'hF);
    tick(0, 0, 5'd0, 4'h0, 0, 0, 5'd0, 4'h0, 1);
    for (int i = 0; i < 10; i++) idle_tick();
    do_reset();
    idle_tick();
    chk("no_done_after_reset", obs_done, 0);
    read_all_a();

    // Randomized traffic with requesters holding until granted.
    ha = 0; hb = 0; hwa = 0; hwb = 0; haa = 0; hab = 0; hda = 0; hdb = 0;
    for (int i = 0; i < 400; i++) begin
      if (!ha && $urandom_range(0, 2) != 0) begin
        ha = 1; hwa = $urandom_range(0, 1); haa = 5'($urandom); hda = 4'($urandom);
      end
      if (!hb && $urandom_range(0, 2) != 0) begin
        hb = 1; hwb = $urandom_range(0, 1); hab = 5'($urandom); hdb = 4'($urandom);
      end
      tick(ha, hwa, haa, hda, hb, hwb, hab, hdb, ($urandom_range(0, 80) == 0));
      if (last_ga) ha = 0;
      if (last_gb) hb = 0;
    end
    for (int i = 0; i < 34; i++) idle_tick();
    read_all_a();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ram32x4_arbiter.md
Name: ram32x4_arbiter

Overview:
- Shares one single-port 32x4 synchronous RAM between two requesters, A and B.
- Adds a sequenced clear engine that sweeps every address to a fixed value.
- Sits between the requesters (switch UI, test pattern engine) and the RAM array.
- Drives the RAM address, write-enable and write-data, and returns the RAM read data to whichever requester was granted.

Parameters:
- AW, 5, address width; depth = 2**AW.
- DW, 4, data width.
- CLEAR_VALUE, 0, word written to every address by the clear sweep.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- req_a, req_b  in  1  access request.
- we_a, we_b  in  1  1 = write, 0 = read; valid with req.
- addr_a, addr_b  in  AW  address.
- wdata_a, wdata_b  in  DW  write data.
- gnt_a, gnt_b  out  1  grant; combinational, same cycle as req.
- rvalid_a, rvalid_b  out  1  read data valid; registered, 1-cycle pulse.
- rdata  out  DW  read data; equals mem_rdata, qualified by rvalid_x.
- clr_start  in  1  starts the clear sweep.
- busy  out  1  clear sweep in progress.
- clr_done  out  1  1-cycle pulse when the sweep completes.
- mem_addr  out  AW  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM registered read output, valid the cycle after the access edge.

Behaviour:
- FSM states: IDLE, CLEAR. Reset enters IDLE.
- Reset values: gnt_a/b = 0, rvalid_a/b = 0, busy = 0, clr_done = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, clear counter = 0, last_grant = B (so A wins the first tie).
- IDLE, clr_start = 0:
  - Exactly one grant per cycle at most; never both.
  - Only one requesting: that requester is granted.
  - Both requesting: grant the one that is not last_grant (round-robin).
  - last_grant updates only on cycles where a grant is issued.
- A grant drives mem_addr/mem_we/mem_wdata from the granted requester. The RAM performs the access at the closing edge.
- Read latency: a granted read in cycle t gives rvalid_x = 1 with rdata valid in cycle t+1. A granted write produces no rvalid.
- Ungranted requesters must hold req/we/addr/wdata until granted. The arbiter keeps no request queue.
- No grant in a cycle: mem_we = 0 and mem_addr holds its last value.
- IDLE, clr_start = 1: no grants that cycle, mem_we = 0. Next edge enters CLEAR with counter = 0.
- CLEAR:
  - busy = 1, gnt_a/b = 0.
  - mem_we = 1, mem_addr = counter, mem_wdata = CLEAR_VALUE.
  - Counter increments each edge.
  - Exactly 2**AW cycles (addresses 0..31 in order).
  - Edge at counter = 31 returns to IDLE; clr_done = 1 for the next cycle only.
  - clr_start during CLEAR is ignored (no restart, no extension).
- Read granted in the cycle before CLEAR is entered: its rvalid still pulses in the first CLEAR cycle.
- Reset asserted mid-sweep:
  - Immediate return to IDLE with counter = 0 and no clr_done.
  - Partially cleared contents are left as-is.
- Counter is AW bits and wraps naturally. The terminal compare is at all-ones.

Optional Feature:
- Macro RAM_ARB_FIXED_PRIO_EN.
- Defined: requester A always wins a tie; last_grant is unused and may be removed.
- Undefined (default): round-robin as above.
- Clear-engine behaviour is identical in both builds.

Test Plan:
- Reset, then A writes addr 5 = 4'hA, later A reads addr 5 -> gnt_a in request cycle; rvalid_a next cycle with rdata = 4'hA; rvalid_b stays 0.
- req_a and req_b held high for 4 cycles, both reads (round-robin build) -> grants A, B, A, B; each rvalid follows its grant by exactly 1 cycle.
- Same stimulus with RAM_ARB_FIXED_PRIO_EN -> gnt_a = 1 all 4 cycles, gnt_b = 0.
- Fill all 32 addresses with 4'hF, pulse clr_start, hold req_b high -> busy for 32 cycles, mem_addr 0..31, no gnt_b during sweep; clr_done pulses once; gnt_b in the first cycle after; every address then reads 4'h0.
- Pulse clr_start, assert Reset at sweep cycle 10 -> busy = 0 immediately, no clr_done; addr 0..9 read 0, addr 10..31 read 4'hF.
- A read granted the same cycle clr_start rises -> no grant that cycle; a read granted the cycle before clr_start -> rvalid still delivered; clr_start pulsed mid-sweep -> sweep still ends after exactly 32 cycles.
